// File: rtl/bit_unroute_pkg.sv
// ============================================================================
// Module : bit_unroute_pkg
// Brief  : Shared FSM state type and chip-word bit-reversal helper for the
//          bit_unroute collector.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bit_unroute_pkg;

  localparam int C_BIT_CHIP = 6;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  function automatic logic [C_BIT_CHIP-1:0] bit_rev(input logic [C_BIT_CHIP-1:0] w);
    logic [C_BIT_CHIP-1:0] r;
    for (int j = 0; j < C_BIT_CHIP; j++) begin
      r[j] = w[C_BIT_CHIP-1-j];
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bit_unroute_lane.sv
// ============================================================================
// Module : bit_unroute_lane
// Brief  : Restores native bit order of one rerouted chip word; with
//          BIT_UNROUTE_PARITY_EN defined it also flags an even-parity error.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bit_unroute_lane
  import bit_unroute_pkg::*;
#(
  parameter int BIT_CHIP = 6
) (
  input  logic [BIT_CHIP-1:0] word_in,
  output logic [BIT_CHIP-1:0] word_nat
`ifdef BIT_UNROUTE_PARITY_EN
  ,
  input  logic                par_in,
  output logic                par_bad
`endif
);

  // The package helper is fixed at its default width; other widths use a bit loop.
  generate
    if (BIT_CHIP == C_BIT_CHIP) begin : g_pkg_rev
      assign word_nat = bit_rev(word_in);
    end else begin : g_loop_rev
      for (genvar j = 0; j < BIT_CHIP; j++) begin : g_bit
        assign word_nat[j] = word_in[BIT_CHIP-1-j];
      end
    end
  endgenerate

`ifdef BIT_UNROUTE_PARITY_EN
  assign par_bad = par_in != (^word_in);
`endif

endmodule

`default_nettype wire

// File: rtl/bit_unroute_collector.sv
// ============================================================================
// Module : bit_unroute_collector
// Brief  : Collects NODE bit-reversed chip words into one native-order frame
//          and hands it off over valid/ready. Optional parity checking is
//          enabled by defining BIT_UNROUTE_PARITY_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bit_unroute_collector
  import bit_unroute_pkg::*;
#(
  parameter int BIT_CHIP = 6,
  parameter int NODE     = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     word_valid,
  input  logic [BIT_CHIP-1:0]      word_data,
  output logic                     word_ready,
  input  logic                     frame_abort,
  output logic                     frame_valid,
  output logic [BIT_CHIP*NODE-1:0] frame_data,
  input  logic                     frame_ready
`ifdef BIT_UNROUTE_PARITY_EN
  ,
  input  logic                     word_par,
  output logic                     par_err
`endif
);

  localparam int c_cnt_w = (NODE > 1) ? $clog2(NODE) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(NODE - 1);

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [c_cnt_w-1:0]         r_cnt;
  logic                       r_frame_valid;
  logic [BIT_CHIP*NODE-1:0]   r_frame;
  logic [BIT_CHIP-1:0]        w_word_nat;
  logic                       w_accept;
  logic                       w_last;

  assign word_ready  = (r_state == FILL);
  assign w_accept    = word_valid & word_ready & ~frame_abort;
  assign w_last      = (r_cnt == c_last);
  assign frame_valid = r_frame_valid;
  assign frame_data  = r_frame;

`ifdef BIT_UNROUTE_PARITY_EN
  logic w_par_bad;
  logic r_sticky;
  logic r_par_err;

  bit_unroute_lane #(.BIT_CHIP(BIT_CHIP)) u_lane (
    .word_in  (word_data),
    .word_nat (w_word_nat),
    .par_in   (word_par),
    .par_bad  (w_par_bad)
  );
`else
  bit_unroute_lane #(.BIT_CHIP(BIT_CHIP)) u_lane (
    .word_in  (word_data),
    .word_nat (w_word_nat)
  );
`endif

  always_comb begin
    w_state_nxt = r_state;
    if (frame_abort) begin
      w_state_nxt = FILL;
    end else begin
      case (r_state)
        FILL:    if (w_accept && w_last) w_state_nxt = HOLD;
        HOLD:    if (frame_ready)        w_state_nxt = FILL;
        default: w_state_nxt = FILL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= FILL;
      r_cnt         <= '0;
      r_frame_valid <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_frame_valid <= (w_state_nxt == HOLD);
      if (frame_abort) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      end
    end
  end

  // Slot decoder: only the slot addressed by cnt is written on an accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame <= '0;
    end else if (w_accept) begin
      for (int k = 0; k < NODE; k++) begin
        if (r_cnt == c_cnt_w'(k)) begin
          r_frame[k*BIT_CHIP +: BIT_CHIP] <= w_word_nat;
        end
      end
    end
  end

`ifdef BIT_UNROUTE_PARITY_EN
  // The sticky bit collects errors while filling; par_err snapshots it, last word included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sticky  <= 1'b0;
      r_par_err <= 1'b0;
    end else if (frame_abort) begin
      r_sticky  <= 1'b0;
      r_par_err <= 1'b0;
    end else if (w_accept && w_last) begin
      r_par_err <= r_sticky | w_par_bad;
      r_sticky  <= 1'b0;
    end else if (w_accept) begin
      r_sticky  <= r_sticky | w_par_bad;
    end else if ((r_state == HOLD) && frame_ready) begin
      r_par_err <= 1'b0;
    end
  end

  assign par_err = r_par_err;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bit_unroute_collector.sv
// ============================================================================
// Module : tb_bit_unroute_collector
// Brief  : Self-checking bench for bit_unroute_collector (default parameters);
//          parity scenarios are built when BIT_UNROUTE_PARITY_EN is defined.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bit_unroute_collector;

  localparam int BC = 6;
  localparam int N  = 16;
  localparam int FW = BC * N;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          word_valid = 1'b0;
  logic [BC-1:0] word_data = '0;
  logic          word_ready;
  logic          frame_abort = 1'b0;
  logic          frame_valid;
  logic [FW-1:0] frame_data;
  logic          frame_ready = 1'b0;
`ifdef BIT_UNROUTE_PARITY_EN
  logic          word_par = 1'b0;
  logic          par_err;
  logic          spar [N];
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  logic [BC-1:0] sent [N];

  always #5 clk = ~clk;

  bit_unroute_collector #(.BIT_CHIP(BC), .NODE(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .word_valid  (word_valid),
    .word_data   (word_data),
    .word_ready  (word_ready),
    .frame_abort (frame_abort),
    .frame_valid (frame_valid),
    .frame_data  (frame_data),
    .frame_ready (frame_ready)
`ifdef BIT_UNROUTE_PARITY_EN
    ,
    .word_par    (word_par),
    .par_err     (par_err)
`endif
  );

  // Reference: each sent word placed with its bits mirrored into its node slot.
  function automatic logic [FW-1:0] exp_frame();
    logic [FW-1:0] f;
    logic [BC-1:0] rev;
    f = '0;
    for (int k = 0; k < N; k++) begin
      rev = '0;
      for (int j = 0; j < BC; j++) rev = {rev[BC-2:0], sent[k][j]};
      f = f | (FW'(rev) << (k * BC));
    end
    return f;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_random();
    for (int k = 0; k < N; k++) begin
      sent[k] = BC'($urandom);
`ifdef BIT_UNROUTE_PARITY_EN
      spar[k] = ^sent[k];
`endif
    end
  endtask

  task automatic drive_word(input int k, output logic fv_seen, output logic to);
    logic rdy;
    fv_seen    = 1'b0;
    to         = 1'b1;
    word_valid = 1'b1;
    word_data  = sent[k];
`ifdef BIT_UNROUTE_PARITY_EN
    word_par   = spar[k];
`endif
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      rdy = word_ready;
      if (frame_valid) fv_seen = 1'b1;
      step();
      if (rdy) begin
        to = 1'b0;
        break;
      end
    end
    word_valid = 1'b0;
  endtask

  task automatic drive_frame(input int start, input bit gaps, output logic early, output logic to);
    logic fv, tw;
    early = 1'b0;
    to    = 1'b0;
    for (int k = start; k < N; k++) begin
      if (gaps) begin
        for (int g = 0; g < 40 && $urandom_range(0, 9) >= 3; g++) step();
      end
      drive_word(k, fv, tw);
      early = early | fv;
      to    = to | tw;
    end
  endtask

  task automatic consume();
    frame_ready = 1'b1;
    step();
    frame_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic fv, to, early;
    logic [FW-1:0] ef;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (word_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", word_ready); end
    n_cmp++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL reset_fv: got %b want 0", frame_valid); end
    n_cmp++; if (frame_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h want 0", frame_data); end
    step();
    fill_random();
    for (int k = 0; k < 5; k++) drive_word(k, fv, to);
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    @(negedge clk);
    n_cmp++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_fv: got %b want 0", frame_valid); end
    n_cmp++; if (frame_data !== '0) begin n_fail++; $display("FAIL midreset_data: got %h want 0", frame_data); end
    n_cmp++; if (word_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_ready: got %b want 1", word_ready); end
    step();
    fill_random();
    drive_frame(0, 1'b0, early, to);
    ef = exp_frame();
    n_cmp++; if ({early, to} !== 2'b00) begin n_fail++; $display("FAIL reset_fill_timing: early/timeout %b want 00", {early, to}); end
    @(negedge clk);
    n_cmp++; if (frame_data !== ef) begin n_fail++; $display("FAIL reset_fill_data: got %h want %h", frame_data, ef); end
    step();
    consume();
  endtask

  task automatic test_ordering();
    logic early, to;
    logic [FW-1:0] ef;
    for (int k = 0; k < N; k++) begin
      sent[k] = BC'(k);
`ifdef BIT_UNROUTE_PARITY_EN
      spar[k] = ^sent[k];
`endif
    end
    drive_frame(0, 1'b0, early, to);
    ef = exp_frame();
    n_cmp++; if (early !== 1'b0 || to !== 1'b0) begin n_fail++; $display("FAIL order_early_fv: early/timeout %b%b want 00", early, to); end
    @(negedge clk);
    n_cmp++; if (frame_valid !== 1'b1) begin n_fail++; $display("FAIL order_latency_fv: got %b want 1", frame_valid); end
    n_cmp++; if (frame_data[5:0] !== 6'd0) begin n_fail++; $display("FAIL order_slot0: got %b want 000000", frame_data[5:0]); end
    n_cmp++; if (frame_data[11:6] !== 6'b100000) begin n_fail++; $display("FAIL order_slot1: got %b want 100000", frame_data[11:6]); end
    n_cmp++; if (frame_data[95:90] !== 6'b111100) begin n_fail++; $display("FAIL order_slot15: got %b want 111100", frame_data[95:90]); end
    n_cmp++; if (frame_data !== ef) begin n_fail++; $display("FAIL order_frame: got %h want %h", frame_data, ef); end
    step();
    consume();
    @(negedge clk);
    n_cmp++; if (frame_valid !== 1'b0 || word_ready !== 1'b1) begin n_fail++; $display("FAIL handoff: fv/ready %b%b want 01", frame_valid, word_ready); end
    step();
  endtask

  task automatic test_backpressure();
    logic early, to;
    logic [FW-1:0] held, ef;
    fill_random();
    drive_frame(0, 1'b0, early, to);
    @(negedge clk);
    held = frame_data;
    n_cmp++; if (frame_valid !== 1'b1) begin n_fail++; $display("FAIL bp_fv: got %b want 1", frame_valid); end
    step();
    sent[0]    = BC'($urandom);
    word_valid = 1'b1;
    word_data  = sent[0];
`ifdef BIT_UNROUTE_PARITY_EN
    spar[0]    = ^sent[0];
    word_par   = spar[0];
`endif
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_cmp++;
      if (frame_valid !== 1'b1 || word_ready !== 1'b0 || frame_data !== held) begin
        n_fail++;
        $display("FAIL bp_hold c=%0d: fv=%b ready=%b data=%h want fv=1 ready=0 data=%h", c, frame_valid, word_ready, frame_data, held);
      end
      step();
    end
    frame_ready = 1'b1;
    step();
    frame_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (word_ready !== 1'b1 || frame_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release: ready/fv %b%b want 10", word_ready, frame_valid); end
    step();
    word_valid = 1'b0;
    for (int k = 1; k < N; k++) sent[k] = BC'($urandom);
`ifdef BIT_UNROUTE_PARITY_EN
    for (int k = 1; k < N; k++) spar[k] = ^sent[k];
`endif
    drive_frame(1, 1'b0, early, to);
    ef = exp_frame();
    @(negedge clk);
    n_cmp++; if (frame_valid !== 1'b1 || frame_data !== ef || early !== 1'b0) begin
      n_fail++; $display("FAIL bp_pending_frame: fv=%b early=%b data=%h want fv=1 early=0 data=%h", frame_valid, early, frame_data, ef);
    end
    step();
    consume();
  endtask

  task automatic test_gaps();
    logic early, to;
    logic [FW-1:0] ef;
    for (int f = 0; f < 3; f++) begin
      fill_random();
      drive_frame(0, 1'b1, early, to);
      ef = exp_frame();
      @(negedge clk);
      n_cmp++; if (frame_valid !== 1'b1 || frame_data !== ef || early !== 1'b0 || to !== 1'b0) begin
        n_fail++; $display("FAIL gaps_frame f=%0d: fv=%b early=%b to=%b data=%h want %h", f, frame_valid, early, to, frame_data, ef);
      end
      step();
      consume();
    end
  endtask

  task automatic test_abort();
    logic fv, to, early, seen;
    logic [FW-1:0] ef;
    fill_random();
    for (int k = 0; k < 7; k++) drive_word(k, fv, to);
    word_valid  = 1'b1;
    word_data   = BC'($urandom);
    frame_abort = 1'b1;
    step();
    frame_abort = 1'b0;
    word_valid  = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (frame_valid) seen = 1'b1;
      step();
    end
    n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL abort_no_frame: frame_valid seen %b want 0", seen); end
    fill_random();
    drive_frame(0, 1'b0, early, to);
    ef = exp_frame();
    n_cmp++; if (early !== 1'b0) begin n_fail++; $display("FAIL abort_cnt_restart: early frame_valid %b want 0", early); end
    @(negedge clk);
    n_cmp++; if (frame_valid !== 1'b1 || frame_data !== ef) begin n_fail++; $display("FAIL abort_next_frame: fv=%b data=%h want fv=1 data=%h", frame_valid, frame_data, ef); end
    step();
    consume();
  endtask

`ifdef BIT_UNROUTE_PARITY_EN
  task automatic test_parity();
    logic early, to;
    fill_random();
    spar[3] = ~spar[3];
    drive_frame(0, 1'b0, early, to);
    @(negedge clk);
    n_cmp++; if (frame_valid !== 1'b1 || par_err !== 1'b1) begin n_fail++; $display("FAIL par_word3: fv/par_err %b%b want 11", frame_valid, par_err); end
    step();
    consume();
    @(negedge clk);
    n_cmp++; if (par_err !== 1'b0) begin n_fail++; $display("FAIL par_clear_handoff: got %b want 0", par_err); end
    step();
    fill_random();
    drive_frame(0, 1'b0, early, to);
    @(negedge clk);
    n_cmp++; if (frame_valid !== 1'b1 || par_err !== 1'b0) begin n_fail++; $display("FAIL par_clean: fv/par_err %b%b want 10", frame_valid, par_err); end
    step();
    consume();
    fill_random();
    spar[N-1] = ~spar[N-1];
    drive_frame(0, 1'b0, early, to);
    @(negedge clk);
    n_cmp++; if (frame_valid !== 1'b1 || par_err !== 1'b1) begin n_fail++; $display("FAIL par_last_word: fv/par_err %b%b want 11", frame_valid, par_err); end
    step();
    consume();
  endtask
`endif

  initial begin
    test_reset();
    test_ordering();
    test_backpressure();
    test_gaps();
    test_abort();
`ifdef BIT_UNROUTE_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

endmodule

`default_nettype wire
